// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and the
// sequence detector it feeds.
`timescale 1ns/1ps
package seq_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Patterns the downstream Moore detector watches for
    localparam logic [3:0] PAT_0100 = 4'b0100;
    localparam logic [3:0] PAT_1001 = 4'b1001;

    // Bit-counter width for a word of w bits; never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register with a saturating bit counter.
// Load has priority over shift so a new word can be taken on the same edge
// that the previous word's last bit leaves.
`timescale 1ns/1ps
module seq_piso
    import seq_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int CNT_W  = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_msb,
    output logic [CNT_W-1:0]  o_bit_cnt,
    output logic              o_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;

    // Load a fresh word or shift the current one toward the MSB output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_shreg <= r_shreg << 1;
            if (r_bit_cnt != LAST_CNT) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end else begin
            r_shreg   <= r_shreg;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign o_msb     = r_shreg[WORD_W-1];
    assign o_bit_cnt = r_bit_cnt;
    assign o_last    = (r_bit_cnt == LAST_CNT);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes words over valid/ready, sends them
// MSB-first one bit per clock, then holds the line idle for a per-word gap.
// Outputs other than word_ready decode registered state only, so an async
// reset idles the line immediately.
`timescale 1ns/1ps
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   WORD_W   = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] word_in,
    input  logic [GAP_W-1:0]  gap_len,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              q_out,
    output logic              bit_valid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam int CNT_W = cnt_width(WORD_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GAP_W-1:0]   r_gap_q;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               w_accept;
    logic               w_ready;
    logic               w_shift;
    logic               w_msb;
    logic               w_last;
    logic [CNT_W-1:0]   w_bit_cnt;
    logic               w_gap_nz;
    logic               w_gap_end;

    assign w_accept  = word_valid & w_ready;
    assign w_shift   = (r_state == S_SHIFT);
    assign w_gap_nz  = (r_gap_q != '0);
    assign w_gap_end = (r_gap_cnt == GAP_W'(1));

    seq_piso #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_piso (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_shift   (w_shift),
        .i_data    (word_in),
        .o_msb     (w_msb),
        .o_bit_cnt (w_bit_cnt),
        .o_last    (w_last)
    );

    // Ready depends on state and counters only, never on word_valid
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_SHIFT: w_ready = w_last & ~w_gap_nz;
            S_GAP:   w_ready = w_gap_end;
            default: w_ready = 1'b0;
        endcase
    end

    // Next-state selection; last bit or last gap cycle chains straight into a new word on accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (!w_last) begin
                    w_state_nxt = S_SHIFT;
                end else if (w_gap_nz) begin
                    w_state_nxt = S_GAP;
                end else if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (!w_gap_end) begin
                    w_state_nxt = S_GAP;
                end else if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the gap length of the word being accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_q <= '0;
        end else if (w_accept) begin
            r_gap_q <= gap_len;
        end else begin
            r_gap_q <= r_gap_q;
        end
    end

    // Gap countdown: loaded on the last data bit, counts down while idling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= '0;
        end else if ((r_state == S_SHIFT) && w_last && w_gap_nz) begin
            r_gap_cnt <= r_gap_q;
        end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        q_out       = IDLE_BIT;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_SHIFT: begin
                q_out       = w_msb;
                bit_valid   = 1'b1;
                frame_start = (w_bit_cnt == '0);
                frame_done  = w_last;
                busy        = 1'b1;
            end
            S_GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign word_ready = w_ready;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a queue-based model of the expected line schedule
// plus directed scenarios with hand-computed bit sequences.
`timescale 1ns/1ps
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int   W  = 4;
    localparam int   G  = 4;
    localparam logic IB = 1'b0;

    logic         clk        = 1'b0;
    logic         reset_n    = 1'b0;
    logic [W-1:0] word_in    = '0;
    logic [G-1:0] gap_len    = '0;
    logic         word_valid = 1'b0;
    logic         word_ready;
    logic         q_out;
    logic         bit_valid;
    logic         frame_start;
    logic         frame_done;
    logic         busy;

    seq_pattern_tx #(.WORD_W(W), .GAP_W(G), .IDLE_BIT(IB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .word_in     (word_in),
        .gap_len     (gap_len),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .q_out       (q_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // One entry per future line cycle: data bit or gap cycle
    typedef struct packed {
        logic b;
        logic data;
        logic fs;
        logic fd;
    } ent_t;

    ent_t mq[$];
    ent_t cur   = '0;
    bit   cur_v = 1'b0;

    // Model: a word is taken when nothing is left scheduled after the current cycle
    initial begin : model
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                cur_v = 1'b0;
            end else begin
                if (word_valid && (mq.size() == 0)) begin
                    for (int i = 0; i < W; i++)
                        mq.push_back(ent_t'{b: word_in[W-1-i], data: 1'b1,
                                            fs: (i == 0), fd: (i == W-1)});
                    for (int k = 0; k < int'(gap_len); k++)
                        mq.push_back(ent_t'{b: IB, data: 1'b0, fs: 1'b0, fd: 1'b0});
                end
                if (mq.size() > 0) begin
                    cur   = mq.pop_front();
                    cur_v = 1'b1;
                end else begin
                    cur_v = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        chk("m.q_out",       q_out,       cur_v ? cur.b : IB);
        chk("m.bit_valid",   bit_valid,   cur_v & cur.data);
        chk("m.frame_start", frame_start, cur_v & cur.fs);
        chk("m.frame_done",  frame_done,  cur_v & cur.fd);
        chk("m.busy",        busy,        cur_v);
        chk("m.word_ready",  word_ready,  mq.size() == 0);
    endtask

    task automatic cyc();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic lit(input string nm, input logic q, input logic bv, input logic fs,
                       input logic fd, input logic rdy, input logic bsy);
        chk({nm, ".q_out"},       q_out,       q);
        chk({nm, ".bit_valid"},   bit_valid,   bv);
        chk({nm, ".frame_start"}, frame_start, fs);
        chk({nm, ".frame_done"},  frame_done,  fd);
        chk({nm, ".word_ready"},  word_ready,  rdy);
        chk({nm, ".busy"},        busy,        bsy);
    endtask

    logic [3:0] pat;
    logic [7:0] p8;
    logic [3:0] det_sh;

    initial begin
        // 1: reset state and release
        reset_n = 1'b0;
        repeat (3) cyc();
        lit("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        cyc();
        lit("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 2: single 0100 word, gap 0
        pat = PAT_0100; word_in = PAT_0100; gap_len = 4'd0; word_valid = 1'b1;
        det_sh = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) word_valid = 1'b0;
            if (bit_valid === 1'b1) det_sh = {det_sh[2:0], q_out};
            chk("t2.q_out", q_out, pat[3-i]);
            chk("t2.bit_valid", bit_valid, 1'b1);
            chk("t2.frame_start", frame_start, i == 0);
            chk("t2.frame_done", frame_done, i == 3);
        end
        chk("t2.loopback_0100", det_sh == PAT_0100, 1'b1);
        cyc();
        lit("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: back-to-back 1001 then 0100, no bubble
        p8 = {PAT_1001, PAT_0100}; word_in = PAT_1001; gap_len = 4'd0; word_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) word_in = PAT_0100;
            if (i == 4) word_valid = 1'b0;
            chk("t3.q_out", q_out, p8[7-i]);
            chk("t3.bit_valid", bit_valid, 1'b1);
            if (i == 2) chk("t3.ready_mid", word_ready, 1'b0);
            if (i == 3) chk("t3.ready_bit4", word_ready, 1'b1);
            if (i == 4) chk("t3.fs_second", frame_start, 1'b1);
        end
        cyc();
        lit("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: 1001 with gap 3, next word 0110 waiting
        word_in = PAT_1001; gap_len = 4'd3; word_valid = 1'b1;
        cyc();
        word_in = 4'b0110; gap_len = 4'd0;
        chk("t4.q_first", q_out, 1'b1);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("t4.ready_shift", word_ready, 1'b0);
        end
        for (int g = 0; g < 3; g++) begin
            cyc();
            lit("t4_gap", IB, 1'b0, 1'b0, 1'b0, g == 2, 1'b1);
        end
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) word_valid = 1'b0;
            chk("t4.q_next", q_out, pat[3-i]);
            chk("t4.bv_next", bit_valid, 1'b1);
            if (i == 0) chk("t4.fs_next", frame_start, 1'b1);
        end
        cyc();
        lit("t4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: reset after two bits of 1001
        word_in = PAT_1001; gap_len = 4'd0; word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        chk("t5.bit1", q_out, 1'b1);
        cyc();
        chk("t5.bit2", q_out, 1'b0);
        #1 reset_n = 1'b0;
        #1 lit("t5_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        reset_n = 1'b1; word_in = PAT_0100; word_valid = 1'b1;
        pat = PAT_0100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) word_valid = 1'b0;
            chk("t5.q_after", q_out, pat[3-i]);
            chk("t5.fs_after", frame_start, i == 0);
        end
        cyc();
        lit("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: no valid at end of gap while word_in toggles
        word_in = PAT_1001; gap_len = 4'd2; word_valid = 1'b1;
        cyc();
        word_valid = 1'b0;
        repeat (3) cyc();
        cyc();
        lit("t6_gap1", IB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        lit("t6_gap2", IB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            word_in = ~word_in;
            cyc();
            lit("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
